// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: seconds/minutes/hours counters advanced by a 1 Hz strobe,
// plus a set-time FSM driven by pre-debounced mode/up button pulses.
//
// Ports:
//   clk      - system clock
//   rst      - asynchronous active-low reset
//   en_1hz   - 1-cycle strobe, once per second
//   btn_mode - 1-cycle pulse, steps RUN -> SET_H -> SET_M -> SET_S -> RUN
//   btn_up   - 1-cycle pulse, increments the field selected in a SET mode
//   hour     - current hour, 0..HOUR_MAX
//   min      - current minute, 0..59
//   sec      - current second, 0..59
//   mode     - 0=RUN 1=SET_H 2=SET_M 3=SET_S
//   blink    - blink enable for the selected field (0 in RUN)
//   day_tick - 1-cycle pulse on HOUR_MAX:59:59 -> 0:00:00 rollover
module clock_time_ctrl #(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned H_INIT   = 0,
  parameter int unsigned M_INIT   = 0,
  parameter int unsigned S_INIT   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [1:0] mode,
  output logic       blink,
  output logic       day_tick
);

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } mode_e;

  mode_e      mode_q, mode_d, mode_next;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;
  logic       blink_q, blink_d;
  logic       day_tick_q, day_tick_d;

  logic sec_wrap, min_wrap, hour_wrap;

  assign sec_wrap  = (sec_q == 6'd59);
  assign min_wrap  = (min_q == 6'd59);
  assign hour_wrap = (hour_q == HOUR_MAX[4:0]);

  always_comb begin
    mode_next = StRun;
    case (mode_q)
      StRun:   mode_next = StSetH;
      StSetH:  mode_next = StSetM;
      StSetM:  mode_next = StSetS;
      StSetS:  mode_next = StRun;
      default: mode_next = StRun;
    endcase
  end

  always_comb begin
    mode_d     = mode_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    blink_d    = blink_q;
    day_tick_d = 1'b0;

    // Timekeeping runs only in RUN; it still advances on a cycle where btn_mode
    // also leaves RUN, since the mode decision uses the current mode.
    if (mode_q == StRun && en_1hz) begin
      if (sec_wrap) begin
        sec_d = 6'd0;
        if (min_wrap) begin
          min_d = 6'd0;
          if (hour_wrap) begin
            hour_d     = 5'd0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (btn_mode) begin
      // Mode change wins: btn_up is dropped and a pending blink toggle is ignored.
      mode_d  = mode_next;
      blink_d = (mode_next != StRun);
    end else if (mode_q != StRun) begin
      if (btn_up) begin
        case (mode_q)
          StSetH:  hour_d = hour_wrap ? 5'd0 : hour_q + 5'd1;
          StSetM:  min_d  = min_wrap  ? 6'd0 : min_q + 6'd1;
          StSetS:  sec_d  = sec_wrap  ? 6'd0 : sec_q + 6'd1;
          default: ;
        endcase
      end
      if (en_1hz) begin
        blink_d = ~blink_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q     <= StRun;
      hour_q     <= H_INIT[4:0];
      min_q      <= M_INIT[5:0];
      sec_q      <= S_INIT[5:0];
      blink_q    <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      blink_q    <= blink_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign mode     = mode_q;
  assign blink    = blink_q;
  assign day_tick = day_tick_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic [4:0] hour, hour2;
  logic [5:0] min, min2, sec, sec2;
  logic [1:0] mode, mode2;
  logic       blink, blink2, day_tick, day_tick2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_time_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .en_1hz   (en_1hz),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .hour     (hour),
    .min      (min),
    .sec      (sec),
    .mode     (mode),
    .blink    (blink),
    .day_tick (day_tick)
  );

  clock_time_ctrl #(
    .HOUR_MAX (23),
    .H_INIT   (23),
    .M_INIT   (59),
    .S_INIT   (59)
  ) dut2 (
    .clk      (clk),
    .rst      (rst),
    .en_1hz   (en_1hz),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .hour     (hour2),
    .min      (min2),
    .sec      (sec2),
    .mode     (mode2),
    .blink    (blink2),
    .day_tick (day_tick2)
  );

  typedef struct packed {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic [1:0] md;
    logic       bl;
    logic       tk;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  // Reference model of the default-parameter DUT.
  int m_h, m_m, m_s, m_mode, m_blink, m_tick;

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_blink = 0; m_tick = 0;
  endtask

  task automatic model_step(input logic en, input logic bm, input logic bu);
    m_tick = 0;
    if (m_mode == 0 && en) begin
      m_s++;
      if (m_s == 60) begin
        m_s = 0;
        m_m++;
        if (m_m == 60) begin
          m_m = 0;
          m_h++;
          if (m_h == 24) begin
            m_h = 0;
            m_tick = 1;
          end
        end
      end
    end
    if (bm) begin
      m_mode  = (m_mode + 1) % 4;
      m_blink = (m_mode != 0) ? 1 : 0;
    end else if (m_mode != 0) begin
      if (bu) begin
        if (m_mode == 1) m_h = (m_h + 1) % 24;
        if (m_mode == 2) m_m = (m_m + 1) % 60;
        if (m_mode == 3) m_s = (m_s + 1) % 60;
      end
      if (en) m_blink = 1 - m_blink;
    end
  endtask

  // Drives one clock of stimulus and queues the model's prediction for that edge.
  task automatic cycle(input logic en, input logic bm, input logic bu);
    exp_t e;
    en_1hz = en; btn_mode = bm; btn_up = bu;
    model_step(en, bm, bu);
    e.h = 5'(m_h); e.m = 6'(m_m); e.s = 6'(m_s);
    e.md = 2'(m_mode); e.bl = 1'(m_blink); e.tk = 1'(m_tick);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    en_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_time(input int h, input int m, input int s);
    cycle(0, 1, 0);
    for (int i = 0; i < h; i++) cycle(0, 0, 1);
    cycle(0, 1, 0);
    for (int i = 0; i < m; i++) cycle(0, 0, 1);
    cycle(0, 1, 0);
    for (int i = 0; i < s; i++) cycle(0, 0, 1);
    cycle(0, 1, 0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({hour, min, sec, mode, blink, day_tick} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_default got=%0d:%0d:%0d m%0d b%0b t%0b want=0:0:0 m0 b0 t0",
               hour, min, sec, mode, blink, day_tick);
    end
    checks++;
    if ({hour2, min2, sec2, mode2, blink2, day_tick2} !==
        {5'd23, 6'd59, 6'd59, 2'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_init got=%0d:%0d:%0d m%0d b%0b t%0b want=23:59:59 m0 b0 t0",
               hour2, min2, sec2, mode2, blink2, day_tick2);
    end
    #1;
    rst = 1'b1;
  endtask

  task automatic test_day_rollover();
    cycle(1, 0, 0);
    checks++;
    if ({hour2, min2, sec2, day_tick2} !== {5'd0, 6'd0, 6'd0, 1'b1}) begin
      failures++;
      $display("FAIL day_rollover got=%0d:%0d:%0d tick=%0b want=0:0:0 tick=1",
               hour2, min2, sec2, day_tick2);
    end
    cycle(0, 0, 0);
    checks++;
    if (day_tick2 !== 1'b0) begin
      failures++;
      $display("FAIL day_tick_width got=%0b want=0", day_tick2);
    end
  endtask

  task automatic test_count();
    int ticks;
    ticks = 0;
    do_reset();
    for (int i = 0; i < 61; i++) begin
      cycle(1, 0, 0);
      if (day_tick) ticks++;
      cycle(0, 0, 0);
      if (day_tick) ticks++;
    end
    checks++;
    if ({hour, min, sec, mode} !== {5'd0, 6'd1, 6'd1, 2'd0}) begin
      failures++;
      $display("FAIL count_61 got=%0d:%0d:%0d m%0d want=0:1:1 m0", hour, min, sec, mode);
    end
    checks++;
    if (ticks != 0) begin
      failures++;
      $display("FAIL count_no_tick got=%0d want=0", ticks);
    end
  endtask

  task automatic test_mode_seq();
    logic [1:0] want [4];
    want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0);
      checks++;
      if (mode !== want[i]) begin
        failures++;
        $display("FAIL mode_seq step%0d got=%0d want=%0d", i, mode, want[i]);
      end
    end
    cycle(0, 1, 0);
    for (int i = 0; i < 23; i++) cycle(0, 0, 1);
    checks++;
    if (hour !== 5'd23) begin
      failures++;
      $display("FAIL set_hour23 got=%0d want=23", hour);
    end
    cycle(0, 0, 1);
    checks++;
    if ({hour, min, sec} !== {5'd0, 6'd0, 6'd0}) begin
      failures++;
      $display("FAIL set_hour_wrap got=%0d:%0d:%0d want=0:0:0", hour, min, sec);
    end
    repeat (3) cycle(0, 1, 0);
  endtask

  task automatic test_set_freeze();
    int toggles;
    logic prev;
    do_reset();
    set_time(7, 20, 40);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    checks++;
    if ({mode, blink} !== {2'd2, 1'b1}) begin
      failures++;
      $display("FAIL set_m_entry got=m%0d b%0b want=m2 b1", mode, blink);
    end
    toggles = 0;
    prev = blink;
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 0);
      if (blink !== prev) toggles++;
      prev = blink;
    end
    checks++;
    if (toggles != 10 || blink !== 1'b1) begin
      failures++;
      $display("FAIL blink_toggle got=%0d toggles end=%0b want=10 toggles end=1", toggles, blink);
    end
    checks++;
    if ({hour, min, sec} !== {5'd7, 6'd20, 6'd40}) begin
      failures++;
      $display("FAIL set_frozen got=%0d:%0d:%0d want=7:20:40", hour, min, sec);
    end
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    checks++;
    if ({mode, blink} !== {2'd0, 1'b0}) begin
      failures++;
      $display("FAIL back_to_run got=m%0d b%0b want=m0 b0", mode, blink);
    end
    cycle(1, 0, 0);
    checks++;
    if (sec !== 6'd41) begin
      failures++;
      $display("FAIL first_sec_after_set got=%0d want=41", sec);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_time(12, 30, 15);
    cycle(0, 1, 1);
    checks++;
    if ({mode, hour, min, sec} !== {2'd1, 5'd12, 6'd30, 6'd15}) begin
      failures++;
      $display("FAIL mode_up_same got=m%0d %0d:%0d:%0d want=m1 12:30:15", mode, hour, min, sec);
    end
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    checks++;
    if ({mode, blink, sec} !== {2'd2, 1'b1, 6'd15}) begin
      failures++;
      $display("FAIL mode_en_set got=m%0d b%0b s%0d want=m2 b1 s15", mode, blink, sec);
    end
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(1, 1, 0);
    checks++;
    if ({mode, blink, sec} !== {2'd1, 1'b1, 6'd16}) begin
      failures++;
      $display("FAIL mode_en_run got=m%0d b%0b s%0d want=m1 b1 s16", mode, blink, sec);
    end
    repeat (3) cycle(0, 1, 0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_time(5, 59, 59);
    checks++;
    if ({hour, min, sec, mode} !== {5'd5, 6'd59, 6'd59, 2'd0}) begin
      failures++;
      $display("FAIL preset_55959 got=%0d:%0d:%0d m%0d want=5:59:59 m0", hour, min, sec, mode);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({hour, min, sec, mode, blink} !== {5'd0, 6'd0, 6'd0, 2'd0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got=%0d:%0d:%0d m%0d b%0b want=0:0:0 m0 b0",
               hour, min, sec, mode, blink);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    cycle(1, 0, 0);
    checks++;
    if ({hour, min, sec} !== {5'd0, 6'd0, 6'd1}) begin
      failures++;
      $display("FAIL after_reset_sec got=%0d:%0d:%0d want=0:0:1", hour, min, sec);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          checks++;
          if ({hour, min, sec, mode, blink, day_tick} !== mon_e) begin
            failures++;
            $display("FAIL scoreboard t=%0t got=%0d:%0d:%0d m%0d b%0b t%0b want=%0d:%0d:%0d m%0d b%0b t%0b",
                     $time, hour, min, sec, mode, blink, day_tick,
                     mon_e.h, mon_e.m, mon_e.s, mon_e.md, mon_e.bl, mon_e.tk);
          end
        end
      end
    join_none

    test_reset();
    test_day_rollover();
    test_count();
    test_mode_seq();
    test_set_freeze();
    test_back_to_back();
    test_reset_mid();

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
